sim_ctrl_dbus_slave: RTL and testbench



---
 rtl/sim_ctrl_pkg.sv | 61 ++++++
 rtl/sim_ctrl_fifo.sv | 65 ++++++
 rtl/sim_ctrl_dbus_slave.sv | 134 +++++++++++++
 tb/tb_sim_ctrl_dbus_slave.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
// Shared definitions for the simulation-control data-bus responder:
// register offsets, STATUS layout, response record and decode helpers.
package sim_ctrl_pkg;

  localparam logic [7:0] OFF_CONSOLE  = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_CYCLE_LO = 8'h08;
  localparam logic [7:0] OFF_CYCLE_HI = 8'h0C;
  localparam logic [7:0] OFF_SCRATCH  = 8'h10;
  localparam logic [7:0] OFF_DONE     = 8'hD0;

  localparam int unsigned STATUS_FULL_BIT  = 0;
  localparam int unsigned STATUS_DONE_BIT  = 1;
  localparam int unsigned STATUS_COUNT_LSB = 8;
  localparam int unsigned STATUS_COUNT_MSB = 15;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } dbus_rsp_t;

  typedef enum logic [2:0] {
    REG_CONSOLE,
    REG_STATUS,
    REG_CYCLE_LO,
    REG_CYCLE_HI,
    REG_SCRATCH,
    REG_DONE,
    REG_NONE
  } reg_sel_e;

  // A miss and an unmapped offset both decode to REG_NONE.
  function automatic reg_sel_e decode_reg(input logic [31:0] addr,
                                          input logic [31:0] base);
    logic [7:0] off;
    off = {addr[7:2], 2'b00};
    if (addr[31:8] != base[31:8]) return REG_NONE;
    case (off)
      OFF_CONSOLE:  return REG_CONSOLE;
      OFF_STATUS:   return REG_STATUS;
      OFF_CYCLE_LO: return REG_CYCLE_LO;
      OFF_CYCLE_HI: return REG_CYCLE_HI;
      OFF_SCRATCH:  return REG_SCRATCH;
      OFF_DONE:     return REG_DONE;
      default:      return REG_NONE;
    endcase
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sim_ctrl_fifo.sv
// Synchronous FIFO for the console character stream; push when full and
// pop when empty are ignored, simultaneous push/pop keeps the count.
module sim_ctrl_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sim_ctrl_dbus_slave.sv
// Data-bus responder in a 256-byte window: done flag, console FIFO,
// 64-bit cycle counter with hi-latch, and a scratch register.
module sim_ctrl_dbus_slave
  import sim_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h80F60000,
  parameter logic [31:0] DONE_DATA  = 32'h0000DEAD,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        char_valid_o,
  output logic [7:0]  char_data_o,
  input  logic        char_ready_i,
  output logic        done_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  dbus_rsp_t   rsp_q, rsp_d;
  logic [63:0] cycle_q, cycle_d;
  logic [31:0] hi_latch_q, hi_latch_d;
  logic [31:0] scratch_q, scratch_d;
  logic        done_q, done_d;

  reg_sel_e    reg_sel;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0] status_word;
  logic        stall;

  sim_ctrl_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (data_wdata_i[7:0]),
    .pop_i   (fifo_pop),
    .data_o  (char_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign char_valid_o  = ~fifo_empty;
  assign fifo_pop      = char_ready_i & ~fifo_empty;
  assign data_rvalid_o = rsp_q.valid;
  assign data_err_o    = rsp_q.err;
  assign data_rdata_o  = rsp_q.rdata;
  assign done_o        = done_q;

  always_comb begin
    status_word = '0;
    status_word[STATUS_FULL_BIT] = fifo_full;
    status_word[STATUS_DONE_BIT] = done_q;
    status_word[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = 8'(fifo_count);
  end

  // Stall uses the pre-pop full flag, so a same-cycle pop never lets a push in.
  always_comb begin
    reg_sel    = decode_reg(data_addr_i, BASE_ADDR);
    stall      = data_req_i & data_we_i & data_be_i[0] &
                 (reg_sel == REG_CONSOLE) & fifo_full;
    data_gnt_o = data_req_i & ~stall;

    rsp_d      = '0;
    fifo_push  = 1'b0;
    scratch_d  = scratch_q;
    done_d     = done_q;
    hi_latch_d = hi_latch_q;
    cycle_d    = cycle_q + 64'd1;

    if (data_gnt_o) begin
      rsp_d.valid = 1'b1;
      case (reg_sel)
        REG_CONSOLE: begin
          if (data_we_i && data_be_i[0]) fifo_push = 1'b1;
        end
        REG_STATUS: begin
          if (!data_we_i) rsp_d.rdata = status_word;
        end
        REG_CYCLE_LO: begin
          if (!data_we_i) begin
            rsp_d.rdata = cycle_q[31:0];
            hi_latch_d  = cycle_q[63:32];
          end
        end
        REG_CYCLE_HI: begin
          if (!data_we_i) rsp_d.rdata = hi_latch_q;
        end
        REG_SCRATCH: begin
          if (data_we_i) scratch_d = be_merge(scratch_q, data_wdata_i, data_be_i);
          else           rsp_d.rdata = scratch_q;
        end
        REG_DONE: begin
          if (data_we_i) begin
            if (data_be_i == 4'hF && data_wdata_i == DONE_DATA) done_d = 1'b1;
          end else begin
            rsp_d.rdata = {31'b0, done_q};
          end
        end
        default: rsp_d.err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_q      <= '0;
      cycle_q    <= '0;
      hi_latch_q <= '0;
      scratch_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      rsp_q      <= rsp_d;
      cycle_q    <= cycle_d;
      hi_latch_q <= hi_latch_d;
      scratch_q  <= scratch_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_sim_ctrl_dbus_slave.sv
// Scoreboard bench for sim_ctrl_dbus_slave: stimulus pushes expected
// responses and console bytes, negedge monitors pop and compare.
module tb_sim_ctrl_dbus_slave;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        err;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
  } exp_rsp_t;

  exp_rsp_t   rsp_q[$];
  logic [7:0] char_q[$];

  localparam logic [31:0] BASE = 32'h80F60000;

  sim_ctrl_dbus_slave #(
    .BASE_ADDR  (32'h80F60000),
    .DONE_DATA  (32'h0000DEAD),
    .FIFO_DEPTH (8)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .data_req_i    (req),
    .data_gnt_o    (gnt),
    .data_rvalid_o (rvalid),
    .data_we_i     (we),
    .data_be_i     (be),
    .data_addr_i   (addr),
    .data_wdata_i  (wdata),
    .data_rdata_o  (rdata),
    .data_err_o    (err),
    .char_valid_o  (char_valid),
    .char_data_o   (char_data),
    .char_ready_i  (char_ready),
    .done_o        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rvalid", 1, 0);
        end else begin
          exp_rsp_t e;
          e = rsp_q.pop_front();
          check({e.name, "_err"}, {63'b0, err}, {63'b0, e.err});
          check({e.name, "_rdata"}, {32'b0, rdata}, {32'b0, e.rdata});
        end
      end else begin
        check("idle_rdata_zero", {32'b0, rdata}, 64'd0);
      end
    end
  end

  // Console monitor: a byte leaves whenever valid and ready meet
  always @(negedge clk) begin
    if (rst_n && char_valid && char_ready) begin
      if (char_q.size() == 0) begin
        check("unexpected_char", 1, 0);
      end else begin
        check("char_order", {56'b0, char_data}, {56'b0, char_q.pop_front()});
      end
    end
  end

  task automatic bus_op(input string name, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err, input logic [31:0] exp_rdata);
    int n;
    exp_rsp_t e;
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    @(negedge clk);
    n = 0;
    while (!gnt && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!gnt) begin
      check({name, "_gnt_timeout"}, 0, 1);
      req = 1'b0;
      return;
    end
    e.name = name; e.err = exp_err; e.rdata = exp_rdata;
    rsp_q.push_back(e);
    if (w && b[0] && a == BASE) char_q.push_back(d[7:0]);
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (char_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, {63'b0, char_valid}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    char_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_gnt", {63'b0, gnt}, 0);
    check("rst_rvalid", {63'b0, rvalid}, 0);
    check("rst_err", {63'b0, err}, 0);
    check("rst_rdata", {32'b0, rdata}, 0);
    check("rst_done", {63'b0, done}, 0);
    check("rst_char_valid", {63'b0, char_valid}, 0);
    @(posedge clk); #1;

    bus_op("rst_scratch", 1'b0, 4'hF, BASE + 32'h10, 0, 1'b0, 32'h0);
    bus_op("rst_status",  1'b0, 4'hF, BASE + 32'h04, 0, 1'b0, 32'h0);

    // Decode errors and read-only writes
    bus_op("err_off20",  1'b0, 4'hF, 32'h80F60020, 0, 1'b1, 32'h0);
    bus_op("err_miss",   1'b0, 4'hF, 32'h80F70000, 0, 1'b1, 32'h0);
    bus_op("err_wr_miss",1'b1, 4'hF, 32'h80F600FC, 32'h1234, 1'b1, 32'h0);
    bus_op("wr_status",  1'b1, 4'hF, BASE + 32'h04, 32'hFFFF, 1'b0, 32'h0);

    // Scratch byte-masked writes; addr[1:0] ignored on the read
    bus_op("scr_w1", 1'b1, 4'hF, BASE + 32'h10, 32'hFFFFFFFF, 1'b0, 32'h0);
    bus_op("scr_w2", 1'b1, 4'h5, BASE + 32'h10, 32'h00000000, 1'b0, 32'h0);
    bus_op("scr_rd", 1'b0, 4'hF, BASE + 32'h13, 0, 1'b0, 32'hFF00FF00);

    // Non-qualifying done writes
    bus_op("done_be3",  1'b1, 4'h3, BASE + 32'hD0, 32'h0000DEAD, 1'b0, 32'h0);
    bus_op("done_beef", 1'b1, 4'hF, BASE + 32'hD0, 32'h0000BEEF, 1'b0, 32'h0);
    @(negedge clk);
    check("done_still_low", {63'b0, done}, 0);
    @(posedge clk); #1;

    // Console ABC
    bus_op("con_A", 1'b1, 4'h1, BASE, 32'h41, 1'b0, 32'h0);
    bus_op("con_B", 1'b1, 4'h1, BASE, 32'h42, 1'b0, 32'h0);
    bus_op("con_C", 1'b1, 4'h1, BASE, 32'h43, 1'b0, 32'h0);
    bus_op("con_nobe0", 1'b1, 4'h2, BASE, 32'h4400, 1'b0, 32'h0);
    bus_op("status_abc", 1'b0, 4'hF, BASE + 32'h04, 0, 1'b0, 32'h00000300);
    bus_op("console_rd", 1'b0, 4'hF, BASE, 0, 1'b0, 32'h0);
    char_ready = 1'b1;
    wait_drain("abc_drained");
    @(posedge clk); #1;
    char_ready = 1'b0;

    // Fill to eight, ninth write stalls until one pop
    for (int i = 0; i < 8; i++) begin
      bus_op("fill", 1'b1, 4'h1, BASE, 32'h30 + i, 1'b0, 32'h0);
    end
    bus_op("status_full", 1'b0, 4'hF, BASE + 32'h04, 0, 1'b0, 32'h00000801);
    fork
      bus_op("ninth", 1'b1, 4'h1, BASE, 32'h38, 1'b0, 32'h0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("full_gnt_low", {63'b0, gnt}, 0);
        end
        @(posedge clk); #1;
        char_ready = 1'b1;
        @(negedge clk);
        check("pop_cycle_gnt_low", {63'b0, gnt}, 0);
        @(posedge clk); #1;
        char_ready = 1'b0;
        @(negedge clk);
        check("after_pop_gnt", {63'b0, gnt}, 1);
      end
    join
    char_ready = 1'b1;
    wait_drain("fill_drained");
    @(posedge clk); #1;
    char_ready = 1'b0;

    // Cycle counter across the low-word carry
    @(negedge clk);
    force dut.cycle_q = 64'h00000000_FFFFFFFE;
    @(negedge clk);
    release dut.cycle_q;
    @(posedge clk); #1;
    bus_op("cyc_lo", 1'b0, 4'hF, BASE + 32'h08, 0, 1'b0, 32'hFFFFFFFF);
    bus_op("cyc_hi", 1'b0, 4'hF, BASE + 32'h0C, 0, 1'b0, 32'h00000000);
    bus_op("cyc_lo2", 1'b0, 4'hF, BASE + 32'h08, 0, 1'b0, 32'h00000001);
    bus_op("cyc_hi2", 1'b0, 4'hF, BASE + 32'h0C, 0, 1'b0, 32'h00000001);

    // Qualifying done write
    bus_op("done_wr", 1'b1, 4'hF, BASE + 32'hD0, 32'h0000DEAD, 1'b0, 32'h0);
    check("done_rise", {63'b0, done}, 1);
    repeat (4) @(posedge clk);
    #1;
    check("done_held", {63'b0, done}, 1);
    bus_op("done_rd",   1'b0, 4'hF, BASE + 32'hD0, 0, 1'b0, 32'h00000001);
    bus_op("status_dn", 1'b0, 4'hF, BASE + 32'h04, 0, 1'b0, 32'h00000002);

    repeat (3) @(negedge clk);
    check("rsp_queue_empty", rsp_q.size(), 0);
    check("char_queue_empty", char_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
